// File: rtl/cvxif_issue_scheduler_if.sv
// CV-X-IF scheduler bundle: issue, commit, exe and result channels.
// The slave side is the scheduler, the master side its environment.
interface cvxif_issue_scheduler_if #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 3,
  parameter int XLEN     = 32,
  parameter int NR_RS    = 3
);
  logic                      issue_valid_i;
  logic                      issue_ready_o;
  logic                      issue_accept_i;
  logic [ID_WIDTH-1:0]       issue_id_i;
  logic [NR_RS*XLEN-1:0]     issue_rs_i;
  logic [4:0]                issue_rd_i;
  logic                      issue_we_i;
  logic                      commit_valid_i;
  logic [ID_WIDTH-1:0]       commit_id_i;
  logic                      commit_kill_i;
  logic                      exe_valid_o;
  logic                      exe_ready_i;
  logic [ID_WIDTH-1:0]       exe_id_o;
  logic [NR_RS*XLEN-1:0]     exe_rs_o;
  logic                      exe_done_i;
  logic [XLEN-1:0]           exe_data_i;
  logic                      result_valid_o;
  logic                      result_ready_i;
  logic [ID_WIDTH-1:0]       result_id_o;
  logic [XLEN-1:0]           result_data_o;
  logic [4:0]                result_rd_o;
  logic                      result_we_o;
  logic [$clog2(DEPTH):0]    count_o;

  modport master (
    output issue_valid_i, issue_accept_i, issue_id_i,
    output issue_rs_i, issue_rd_i, issue_we_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output exe_ready_i, exe_done_i, exe_data_i,
    output result_ready_i,
    input  issue_ready_o, exe_valid_o, exe_id_o, exe_rs_o,
    input  result_valid_o, result_id_o, result_data_o,
    input  result_rd_o, result_we_o, count_o
  );

  modport slave (
    input  issue_valid_i, issue_accept_i, issue_id_i,
    input  issue_rs_i, issue_rd_i, issue_we_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  exe_ready_i, exe_done_i, exe_data_i,
    input  result_ready_i,
    output issue_ready_o, exe_valid_o, exe_id_o, exe_rs_o,
    output result_valid_o, result_id_o, result_data_o,
    output result_rd_o, result_we_o, count_o
  );
endinterface

// File: rtl/cvxif_issue_scheduler.sv
// In-order scoreboard for offloaded CV-X-IF instructions: tracks
// commit/kill, dispatches one at a time, returns results in issue order.
module cvxif_issue_scheduler #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 3,
  parameter int XLEN     = 32,
  parameter int NR_RS    = 3
) (
  input logic                   clk_i,
  input logic                   rst_i,
  cvxif_issue_scheduler_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = NR_RS * XLEN;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_FREE,
    S_ISSUED,
    S_COMMITTED,
    S_KILLED,
    S_EXEC,
    S_DONE
  } ent_e;

  ent_e                st_q   [DEPTH];
  ent_e                st_d   [DEPTH];
  logic [ID_WIDTH-1:0] id_q   [DEPTH];
  logic [ID_WIDTH-1:0] id_d   [DEPTH];
  logic [RW-1:0]       rs_q   [DEPTH];
  logic [RW-1:0]       rs_d   [DEPTH];
  logic [4:0]          rd_q   [DEPTH];
  logic [4:0]          rd_d   [DEPTH];
  logic                we_q   [DEPTH];
  logic                we_d   [DEPTH];
  logic [XLEN-1:0]     data_q [DEPTH];
  logic [XLEN-1:0]     data_d [DEPTH];

  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] disp_ptr_q, disp_ptr_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [PW-1:0] exe_ptr_q, exe_ptr_d;
  // count: allocated entries; pend: allocated but not yet passed by disp_ptr
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          busy_q, busy_d;

  logic issue_ready;
  logic alloc;
  logic exe_valid;
  logic disp_fire;
  logic skip;
  logic done;
  logic res_valid;
  logic res_fire;
  logic kill_free;
  logic freed;
  logic same_commit;

  assign issue_ready = !rst_i && (count_q < FULL);
  assign alloc = bus.issue_valid_i && issue_ready
              && bus.issue_accept_i;
  assign same_commit = bus.commit_valid_i
                    && (bus.commit_id_i == bus.issue_id_i);

  assign exe_valid = !rst_i && !busy_q && (pend_q != '0)
                  && (st_q[disp_ptr_q] == S_COMMITTED);
  assign disp_fire = exe_valid && bus.exe_ready_i;
  assign skip = (pend_q != '0)
             && (st_q[disp_ptr_q] == S_KILLED);
  assign done = bus.exe_done_i && busy_q;

  assign res_valid = !rst_i && (st_q[head_ptr_q] == S_DONE);
  assign res_fire = res_valid && bus.result_ready_i;
  // a killed head may only be dropped once dispatch has moved past it
  assign kill_free = (st_q[head_ptr_q] == S_KILLED)
                  && (count_q != pend_q);
  assign freed = res_fire || kill_free;

  assign bus.issue_ready_o  = issue_ready;
  assign bus.exe_valid_o    = exe_valid;
  assign bus.exe_id_o       = id_q[disp_ptr_q];
  assign bus.exe_rs_o       = rs_q[disp_ptr_q];
  assign bus.result_valid_o = res_valid;
  assign bus.result_id_o    = id_q[head_ptr_q];
  assign bus.result_data_o  = data_q[head_ptr_q];
  assign bus.result_rd_o    = rd_q[head_ptr_q];
  assign bus.result_we_o    = we_q[head_ptr_q];
  assign bus.count_o        = count_q;

  // next-state of entries, pointers and counters
  always_comb begin
    st_d        = st_q;
    id_d        = id_q;
    rs_d        = rs_q;
    rd_d        = rd_q;
    we_d        = we_q;
    data_d      = data_q;
    alloc_ptr_d = alloc_ptr_q;
    disp_ptr_d  = disp_ptr_q;
    head_ptr_d  = head_ptr_q;
    exe_ptr_d   = exe_ptr_q;
    busy_d      = busy_q;

    if (bus.commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (st_q[i] == S_ISSUED
            && id_q[i] == bus.commit_id_i) begin
          st_d[i] = bus.commit_kill_i ? S_KILLED
                                      : S_COMMITTED;
        end
      end
    end

    if (disp_fire) begin
      st_d[disp_ptr_q] = S_EXEC;
      exe_ptr_d        = disp_ptr_q;
      busy_d           = 1'b1;
      disp_ptr_d       = disp_ptr_q + 1'b1;
    end else if (skip) begin
      disp_ptr_d = disp_ptr_q + 1'b1;
    end

    if (done) begin
      st_d[exe_ptr_q]   = S_DONE;
      data_d[exe_ptr_q] = bus.exe_data_i;
      busy_d            = 1'b0;
    end

    if (freed) begin
      st_d[head_ptr_q] = S_FREE;
      head_ptr_d       = head_ptr_q + 1'b1;
    end

    if (alloc) begin
      id_d[alloc_ptr_q] = bus.issue_id_i;
      rs_d[alloc_ptr_q] = bus.issue_rs_i;
      rd_d[alloc_ptr_q] = bus.issue_rd_i;
      we_d[alloc_ptr_q] = bus.issue_we_i;
      if (same_commit) begin
        st_d[alloc_ptr_q] = bus.commit_kill_i ? S_KILLED
                                              : S_COMMITTED;
      end else begin
        st_d[alloc_ptr_q] = S_ISSUED;
      end
      alloc_ptr_d = alloc_ptr_q + 1'b1;
    end

    count_d = count_q + CW'(alloc) - CW'(freed);
    pend_d  = pend_q + CW'(alloc) - CW'(disp_fire || skip);
  end

  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= S_FREE;
        id_q[i]   <= '0;
        rs_q[i]   <= '0;
        rd_q[i]   <= '0;
        we_q[i]   <= 1'b0;
        data_q[i] <= '0;
      end
      alloc_ptr_q <= '0;
      disp_ptr_q  <= '0;
      head_ptr_q  <= '0;
      exe_ptr_q   <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      id_q        <= id_d;
      rs_q        <= rs_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      data_q      <= data_d;
      alloc_ptr_q <= alloc_ptr_d;
      disp_ptr_q  <= disp_ptr_d;
      head_ptr_q  <= head_ptr_d;
      exe_ptr_q   <= exe_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
    end
  end
endmodule

// File: tb/tb_cvxif_issue_scheduler.sv
// Bench for cvxif_issue_scheduler: directed scenarios plus a
// randomized run against an in-order queue model.
module tb_cvxif_issue_scheduler;
  localparam int DEPTH = 4;
  localparam int IDW   = 3;
  localparam int XLEN  = 32;
  localparam int NR_RS = 3;
  localparam int RW    = NR_RS * XLEN;

  localparam int M_ISS  = 0;
  localparam int M_COM  = 1;
  localparam int M_KIL  = 2;
  localparam int M_DISP = 3;

  typedef struct {
    logic [IDW-1:0] id;
    logic [RW-1:0]  rs;
    logic [4:0]     rd;
    logic           we;
    int             st;
  } ment_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  ment_t mq[$];

  always #5 clk = ~clk;

  cvxif_issue_scheduler_if #(
    .DEPTH(DEPTH), .ID_WIDTH(IDW),
    .XLEN(XLEN), .NR_RS(NR_RS)
  ) bus ();

  cvxif_issue_scheduler #(
    .DEPTH(DEPTH), .ID_WIDTH(IDW),
    .XLEN(XLEN), .NR_RS(NR_RS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  function automatic logic [XLEN-1:0] alu(input logic [RW-1:0] rs);
    return rs[31:0] + rs[63:32] + rs[95:64];
  endfunction

  function automatic logic [RW-1:0] rs_of(input int i);
    return {32'(i + 3), 32'(i + 2), 32'(i + 1)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.issue_valid_i  = 1'b0;
    bus.issue_accept_i = 1'b0;
    bus.issue_id_i     = '0;
    bus.issue_rs_i     = '0;
    bus.issue_rd_i     = '0;
    bus.issue_we_i     = 1'b0;
    bus.commit_valid_i = 1'b0;
    bus.commit_id_i    = '0;
    bus.commit_kill_i  = 1'b0;
    bus.exe_ready_i    = 1'b1;
    bus.exe_done_i     = 1'b0;
    bus.exe_data_i     = '0;
    bus.result_ready_i = 1'b0;
  endtask

  task automatic drv_issue(input int id, input logic acc);
    bus.issue_valid_i  = 1'b1;
    bus.issue_accept_i = acc;
    bus.issue_id_i     = IDW'(id);
    bus.issue_rs_i     = rs_of(id);
    bus.issue_rd_i     = 5'(id + 5);
    bus.issue_we_i     = 1'b1;
  endtask

  task automatic drv_commit(input int id, input logic kill);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = IDW'(id);
    bus.commit_kill_i  = kill;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    checks++; if (bus.issue_ready_o !== 1'b0) begin errors++; $display("FAIL rst_issue_ready got %b want 0", bus.issue_ready_o); end
    checks++; if (bus.exe_valid_o !== 1'b0) begin errors++; $display("FAIL rst_exe_valid got %b want 0", bus.exe_valid_o); end
    checks++; if (bus.result_valid_o !== 1'b0) begin errors++; $display("FAIL rst_result_valid got %b want 0", bus.result_valid_o); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.count_o); end
    rst = 1'b0;
    cyc();
    checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", bus.issue_ready_o); end
    checks++; if (bus.result_id_o !== 3'd0 || bus.result_data_o !== 32'd0) begin errors++; $display("FAIL post_rst_result got id %0d data %0h want 0 0", bus.result_id_o, bus.result_data_o); end
    checks++; if (bus.exe_id_o !== 3'd0 || bus.exe_rs_o !== 96'd0) begin errors++; $display("FAIL post_rst_exe got id %0d rs %0h want 0 0", bus.exe_id_o, bus.exe_rs_o); end
    checks++; if (bus.result_rd_o !== 5'd0 || bus.result_we_o !== 1'b0) begin errors++; $display("FAIL post_rst_rd_we got %0d %b want 0 0", bus.result_rd_o, bus.result_we_o); end
  endtask

  task automatic test_same_cycle();
    drv_issue(2, 1'b1);
    bus.issue_rs_i = {32'd3, 32'd2, 32'd1};
    drv_commit(2, 1'b0);
    cyc();
    idle();
    checks++; if (bus.exe_valid_o !== 1'b1 || bus.exe_id_o !== 3'd2) begin errors++; $display("FAIL sc_exe got v%b id %0d want v1 id 2", bus.exe_valid_o, bus.exe_id_o); end
    checks++; if (bus.exe_rs_o !== {32'd3, 32'd2, 32'd1}) begin errors++; $display("FAIL sc_exe_rs got %h want 3,2,1", bus.exe_rs_o); end
    checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL sc_count got %0d want 1", bus.count_o); end
    cyc();
    checks++; if (bus.exe_valid_o !== 1'b0) begin errors++; $display("FAIL sc_busy got %b want 0", bus.exe_valid_o); end
    bus.exe_done_i = 1'b1;
    bus.exe_data_i = 32'd6;
    cyc();
    bus.exe_done_i = 1'b0;
    checks++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 3'd2 || bus.result_data_o !== 32'd6) begin errors++; $display("FAIL sc_result got v%b id %0d d %0d want v1 id 2 d 6", bus.result_valid_o, bus.result_id_o, bus.result_data_o); end
    checks++; if (bus.result_rd_o !== 5'd7 || bus.result_we_o !== 1'b1) begin errors++; $display("FAIL sc_rd_we got %0d %b want 7 1", bus.result_rd_o, bus.result_we_o); end
    bus.result_ready_i = 1'b1;
    cyc();
    bus.result_ready_i = 1'b0;
    checks++; if (bus.result_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL sc_drain got v%b cnt %0d want v0 cnt 0", bus.result_valid_o, bus.count_o); end
  endtask

  task automatic test_in_order();
    int n;
    for (int i = 0; i < 4; i++) begin
      drv_issue(i, 1'b1);
      cyc();
      idle();
    end
    checks++; if (bus.count_o !== 3'd4 || bus.issue_ready_o !== 1'b0) begin errors++; $display("FAIL io_full got cnt %0d rdy %b want 4 0", bus.count_o, bus.issue_ready_o); end
    checks++; if (bus.exe_valid_o !== 1'b0) begin errors++; $display("FAIL io_nodisp got %b want 0", bus.exe_valid_o); end
    drv_commit(1, 1'b0);
    cyc();
    idle();
    checks++; if (bus.exe_valid_o !== 1'b0) begin errors++; $display("FAIL io_stall got %b want 0", bus.exe_valid_o); end
    drv_commit(0, 1'b0);
    cyc();
    idle();
    checks++; if (bus.exe_valid_o !== 1'b1 || bus.exe_id_o !== 3'd0) begin errors++; $display("FAIL io_disp0 got v%b id %0d want v1 id 0", bus.exe_valid_o, bus.exe_id_o); end
    cyc();
    bus.exe_done_i = 1'b1;
    bus.exe_data_i = alu(rs_of(0));
    cyc();
    bus.exe_done_i = 1'b0;
    checks++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 3'd0 || bus.result_data_o !== alu(rs_of(0))) begin errors++; $display("FAIL io_res0 got v%b id %0d d %0h", bus.result_valid_o, bus.result_id_o, bus.result_data_o); end
    checks++; if (bus.exe_valid_o !== 1'b1 || bus.exe_id_o !== 3'd1) begin errors++; $display("FAIL io_disp1 got v%b id %0d want v1 id 1", bus.exe_valid_o, bus.exe_id_o); end
    bus.result_ready_i = 1'b1;
    cyc();
    bus.result_ready_i = 1'b0;
    bus.exe_done_i = 1'b1;
    bus.exe_data_i = alu(rs_of(1));
    cyc();
    bus.exe_done_i = 1'b0;
    checks++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 3'd1 || bus.result_data_o !== alu(rs_of(1))) begin errors++; $display("FAIL io_res1 got v%b id %0d d %0h", bus.result_valid_o, bus.result_id_o, bus.result_data_o); end
    bus.result_ready_i = 1'b1;
    cyc();
    bus.result_ready_i = 1'b0;
    drv_commit(2, 1'b1);
    cyc();
    drv_commit(3, 1'b1);
    cyc();
    idle();
    n = 0;
    while (bus.count_o !== 3'd0 && n < 10) begin
      checks++; if (bus.exe_valid_o !== 1'b0) begin errors++; $display("FAIL io_killed_disp got id %0d want none", bus.exe_id_o); end
      cyc();
      n++;
    end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL io_kill_free got cnt %0d want 0", bus.count_o); end
  endtask

  task automatic test_kill();
    int n_exe;
    int n_res;
    logic dp;
    drv_issue(4, 1'b1);
    cyc();
    drv_issue(5, 1'b1);
    cyc();
    idle();
    drv_commit(4, 1'b1);
    cyc();
    drv_commit(5, 1'b0);
    cyc();
    idle();
    n_exe = 0;
    n_res = 0;
    dp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.exe_done_i = dp;
      bus.exe_data_i = alu(rs_of(5));
      dp = 1'b0;
      if (bus.exe_valid_o) begin
        checks++; if (bus.exe_id_o !== 3'd5) begin errors++; $display("FAIL kill_exe_id got %0d want 5", bus.exe_id_o); end
        n_exe++;
        dp = 1'b1;
      end
      if (bus.result_valid_o) begin
        checks++; if (bus.result_id_o !== 3'd5 || bus.result_data_o !== alu(rs_of(5))) begin errors++; $display("FAIL kill_res got id %0d d %0h want id 5", bus.result_id_o, bus.result_data_o); end
        n_res++;
      end
      bus.result_ready_i = 1'b1;
      cyc();
    end
    idle();
    checks++; if (n_exe != 1 || n_res != 1) begin errors++; $display("FAIL kill_counts got exe %0d res %0d want 1 1", n_exe, n_res); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL kill_count got %0d want 0", bus.count_o); end
  endtask

  task automatic test_backpressure();
    drv_issue(3, 1'b1);
    drv_commit(3, 1'b0);
    cyc();
    idle();
    checks++; if (bus.exe_valid_o !== 1'b1 || bus.exe_id_o !== 3'd3) begin errors++; $display("FAIL bp_disp3 got v%b id %0d", bus.exe_valid_o, bus.exe_id_o); end
    drv_issue(6, 1'b1);
    drv_commit(6, 1'b0);
    cyc();
    idle();
    bus.exe_done_i = 1'b1;
    bus.exe_data_i = alu(rs_of(3));
    cyc();
    bus.exe_done_i = 1'b0;
    checks++; if (bus.exe_valid_o !== 1'b1 || bus.exe_id_o !== 3'd6) begin errors++; $display("FAIL bp_disp6 got v%b id %0d", bus.exe_valid_o, bus.exe_id_o); end
    cyc();
    bus.exe_done_i = 1'b1;
    bus.exe_data_i = alu(rs_of(6));
    cyc();
    bus.exe_done_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 3'd3 || bus.result_data_o !== alu(rs_of(3)) || bus.result_rd_o !== 5'd8) begin errors++; $display("FAIL bp_hold cycle %0d got v%b id %0d d %0h", k, bus.result_valid_o, bus.result_id_o, bus.result_data_o); end
      cyc();
    end
    bus.result_ready_i = 1'b1;
    cyc();
    checks++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 3'd6 || bus.result_data_o !== alu(rs_of(6))) begin errors++; $display("FAIL bp_next got v%b id %0d d %0h want id 6", bus.result_valid_o, bus.result_id_o, bus.result_data_o); end
    cyc();
    bus.result_ready_i = 1'b0;
    checks++; if (bus.result_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL bp_drain got v%b cnt %0d", bus.result_valid_o, bus.count_o); end
  endtask

  task automatic test_ignored();
    int n;
    drv_commit(7, 1'b0);
    cyc();
    idle();
    drv_issue(1, 1'b0);
    cyc();
    idle();
    checks++; if (bus.count_o !== 3'd0 || bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL ign_count got cnt %0d rdy %b want 0 1", bus.count_o, bus.issue_ready_o); end
    checks++; if (bus.exe_valid_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin errors++; $display("FAIL ign_valid got %b %b want 0 0", bus.exe_valid_o, bus.result_valid_o); end
    drv_issue(7, 1'b1);
    cyc();
    idle();
    cyc();
    checks++; if (bus.exe_valid_o !== 1'b0 || bus.count_o !== 3'd1) begin errors++; $display("FAIL ign_stale got v%b cnt %0d want 0 1", bus.exe_valid_o, bus.count_o); end
    drv_commit(7, 1'b1);
    cyc();
    idle();
    n = 0;
    while (bus.count_o !== 3'd0 && n < 6) begin
      cyc();
      n++;
    end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL ign_kill got cnt %0d want 0", bus.count_o); end
  endtask

  task automatic test_reset_mid();
    drv_issue(1, 1'b1);
    drv_commit(1, 1'b0);
    cyc();
    idle();
    drv_issue(2, 1'b1);
    cyc();
    drv_issue(3, 1'b1);
    cyc();
    idle();
    checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL rm_pre got cnt %0d want 3", bus.count_o); end
    rst = 1'b1;
    cyc();
    checks++; if (bus.count_o !== 3'd0 || bus.issue_ready_o !== 1'b0) begin errors++; $display("FAIL rm_rst got cnt %0d rdy %b want 0 0", bus.count_o, bus.issue_ready_o); end
    checks++; if (bus.exe_valid_o !== 1'b0 || bus.result_valid_o !== 1'b0 || bus.exe_id_o !== 3'd0 || bus.result_id_o !== 3'd0) begin errors++; $display("FAIL rm_outs got ev%b rv%b eid %0d rid %0d", bus.exe_valid_o, bus.result_valid_o, bus.exe_id_o, bus.result_id_o); end
    rst = 1'b0;
    bus.exe_done_i = 1'b1;
    bus.exe_data_i = 32'h123;
    cyc();
    bus.exe_done_i = 1'b0;
    checks++; if (bus.result_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL rm_done got v%b cnt %0d want 0 0", bus.result_valid_o, bus.count_o); end
    cyc();
    checks++; if (bus.result_valid_o !== 1'b0 || bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL rm_after got v%b rdy %b want 0 1", bus.result_valid_o, bus.issue_ready_o); end
  endtask

  task automatic test_random();
    bit dp_busy;
    int dp_cnt;
    logic [XLEN-1:0] dp_data;
    int nres;
    int nk;
    int idx;
    bit drain;
    bit rr;
    bit er;
    bit iv;
    bit acc;
    bit used;
    logic [IDW-1:0] iid;
    logic [IDW-1:0] cid;
    logic [IDW-1:0] cand[$];
    int iss[$];
    ment_t keep[$];
    ment_t ne;
    dp_busy = 1'b0;
    dp_cnt = 0;
    dp_data = '0;
    nres = 0;
    mq.delete();
    for (int cy = 0; cy < 1000; cy++) begin
      drain = (cy >= 600);
      nk = 0;
      foreach (mq[j]) if (mq[j].st != M_KIL) nk++;
      checks++; if (int'(bus.count_o) > mq.size() || int'(bus.count_o) < nk) begin errors++; $display("FAIL rnd_count cycle %0d got %0d want %0d..%0d", cy, bus.count_o, nk, mq.size()); end
      if (mq.size() < DEPTH) begin
        checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL rnd_ready cycle %0d got %b want 1", cy, bus.issue_ready_o); end
      end
      checks++; if (dp_busy && bus.exe_valid_o) begin errors++; $display("FAIL rnd_exe_busy cycle %0d got exe_valid 1 want 0", cy); end
      if (bus.count_o == 0) begin
        keep.delete();
        foreach (mq[j]) if (mq[j].st != M_KIL) keep.push_back(mq[j]);
        mq = keep;
      end
      if (drain && bus.count_o == 0 && mq.size() == 0 && !dp_busy) break;
      bus.exe_done_i = 1'b0;
      if (dp_busy) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          bus.exe_done_i = 1'b1;
          bus.exe_data_i = dp_data;
          dp_busy = 1'b0;
        end
      end
      rr = drain ? 1'b1 : ($urandom % 4 != 0);
      bus.result_ready_i = rr;
      if (bus.result_valid_o && rr) begin
        while (mq.size() > 0 && mq[0].st == M_KIL) void'(mq.pop_front());
        checks++;
        if (mq.size() == 0 || mq[0].st != M_DISP) begin
          errors++; $display("FAIL rnd_res_order cycle %0d got id %0d want no result", cy, bus.result_id_o);
        end else begin
          if (bus.result_id_o !== mq[0].id || bus.result_data_o !== alu(mq[0].rs) || bus.result_rd_o !== mq[0].rd || bus.result_we_o !== mq[0].we) begin
            errors++; $display("FAIL rnd_res cycle %0d got id %0d d %0h want id %0d d %0h", cy, bus.result_id_o, bus.result_data_o, mq[0].id, alu(mq[0].rs));
          end
          void'(mq.pop_front());
          nres++;
        end
      end
      er = drain ? 1'b1 : ($urandom % 3 != 0);
      bus.exe_ready_i = er;
      if (bus.exe_valid_o && er) begin
        idx = -1;
        foreach (mq[j]) if (idx < 0 && (mq[j].st == M_ISS || mq[j].st == M_COM)) idx = j;
        checks++;
        if (idx < 0) begin
          errors++; $display("FAIL rnd_exe cycle %0d got id %0d want no dispatch", cy, bus.exe_id_o);
        end else begin
          if (mq[idx].st != M_COM || bus.exe_id_o !== mq[idx].id || bus.exe_rs_o !== mq[idx].rs) begin
            errors++; $display("FAIL rnd_exe cycle %0d got id %0d want id %0d committed", cy, bus.exe_id_o, mq[idx].id);
          end
          mq[idx].st = M_DISP;
          dp_busy = 1'b1;
          dp_cnt = $urandom_range(1, 3);
          dp_data = alu(mq[idx].rs);
        end
      end
      bus.issue_valid_i = 1'b0;
      bus.issue_accept_i = 1'b0;
      iv = 1'b0;
      iid = '0;
      if (!drain && ($urandom % 2 == 1)) begin
        cand.delete();
        for (int v = 0; v < 8; v++) begin
          used = 1'b0;
          foreach (mq[j]) if (int'(mq[j].id) == v) used = 1'b1;
          if (!used) cand.push_back(IDW'(v));
        end
        if (cand.size() > 0) begin
          iv = 1'b1;
          iid = cand[$urandom_range(0, cand.size() - 1)];
          acc = ($urandom % 4 != 0);
          ne.id = iid;
          ne.rs = {$urandom, $urandom, $urandom};
          ne.rd = 5'($urandom);
          ne.we = 1'($urandom);
          ne.st = M_ISS;
          bus.issue_valid_i = 1'b1;
          bus.issue_accept_i = acc;
          bus.issue_id_i = ne.id;
          bus.issue_rs_i = ne.rs;
          bus.issue_rd_i = ne.rd;
          bus.issue_we_i = ne.we;
          if (bus.issue_ready_o && acc) mq.push_back(ne);
        end
      end
      bus.commit_valid_i = 1'b0;
      iss.delete();
      foreach (mq[j]) if (mq[j].st == M_ISS) iss.push_back(j);
      cid = '0;
      if (drain) begin
        if (iss.size() > 0) begin
          bus.commit_valid_i = 1'b1;
          cid = mq[iss[0]].id;
        end
      end else if ($urandom % 2 == 1) begin
        bus.commit_valid_i = 1'b1;
        if (iv && $urandom % 2 == 1) cid = iid;
        else if (iss.size() > 0 && $urandom % 4 != 0) cid = mq[iss[$urandom_range(0, iss.size() - 1)]].id;
        else cid = IDW'($urandom);
      end
      bus.commit_id_i = cid;
      bus.commit_kill_i = ($urandom % 4 == 0);
      if (bus.commit_valid_i) begin
        foreach (mq[j]) begin
          if (mq[j].id == cid && mq[j].st == M_ISS) mq[j].st = bus.commit_kill_i ? M_KIL : M_COM;
        end
      end
      cyc();
    end
    idle();
    checks++; if (mq.size() != 0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL rnd_drain got model %0d cnt %0d want 0 0", mq.size(), bus.count_o); end
    checks++; if (nres < 20) begin errors++; $display("FAIL rnd_activity got %0d results want >=20", nres); end
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_same_cycle();
    test_in_order();
    test_kill();
    test_backpressure();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
